// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, count-width helper and error-flag bit positions.
package fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  // Bit positions inside the error vector, shared with the dual-clock FIFO status word.
  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

  function automatic int cnt_w(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Storage array for the FIFOs: synchronous write port, asynchronous read port, no reset.
module fifo_dpram #(
  parameter int dsize = 8,
  parameter int asize = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [asize-1:0] waddr,
  input  logic [dsize-1:0] wdata,
  input  logic [asize-1:0] raddr,
  output logic [dsize-1:0] rdata
);

  logic [dsize-1:0] mem [2**asize];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_flex.sv
// Single-clock FIFO with fill count, almost flags, sticky errors, flush and optional output register.
module sfifo_flex
  import fifo_pkg::*;
#(
  parameter int dsize  = DSIZE_DEF,
  parameter int asize  = ASIZE_DEF,
  parameter int afull  = 14,
  parameter int aempty = 2,
  parameter int oreg   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             err_clr,
  input  logic             wren,
  input  logic [dsize-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rden,
  output logic [dsize-1:0] rdata,
  output logic             rvalid,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [asize:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = cnt_w(asize);
  localparam logic [CW-1:0] DEPTH_C  = CW'(2**asize);
  localparam logic [CW-1:0] AFULL_C  = CW'(afull);
  localparam logic [CW-1:0] AEMPTY_C = CW'(aempty);

  logic [CW-1:0]     wbin, rbin, wbin_next, rbin_next, count_next;
  logic              wr_acc, rd_acc;
  logic [ERR_W-1:0]  err, err_set, err_next;
  logic [dsize-1:0]  ram_q;

  // Flush discards any concurrent request so no pointer moves and no error is raised.
  assign wr_acc = wren && !wfull && !flush;
  assign rd_acc = rden && !rempty && !flush;

  assign wbin_next  = flush ? '0 : wbin + CW'(wr_acc);
  assign rbin_next  = flush ? '0 : rbin + CW'(rd_acc);
  assign count_next = wbin_next - rbin_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbin          <= '0;
      rbin          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      walmost_full  <= 1'b0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
    end else begin
      wbin          <= wbin_next;
      rbin          <= rbin_next;
      count         <= count_next;
      wfull         <= (count_next == DEPTH_C);
      walmost_full  <= (count_next >= AFULL_C);
      rempty        <= (wbin_next == rbin_next);
      ralmost_empty <= (count_next <= AEMPTY_C);
    end
  end

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = wren && wfull && !flush;
    err_set[ERR_UDF] = rden && rempty && !flush;
    // A new error in the same cycle as err_clr stays set.
    if (flush) err_next = '0;
    else       err_next = err_set | (err & {ERR_W{!err_clr}});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err <= '0;
    else       err <= err_next;
  end

  assign overflow  = err[ERR_OVF];
  assign underflow = err[ERR_UDF];

  fifo_dpram #(.dsize(dsize), .asize(asize)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wbin[asize-1:0]),
    .wdata (wdata),
    .raddr (rbin[asize-1:0]),
    .rdata (ram_q)
  );

  generate
    if (oreg == 0) begin : g_show_ahead
      assign rdata  = ram_q;
      assign rvalid = !rempty;
    end else begin : g_oreg
      logic [dsize-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (flush) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) rdata_q <= ram_q;
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sfifo_flex.sv
// Self-checking bench for sfifo_flex: queue model compared every cycle plus directed literal checks.
module tb_sfifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, flush, err_clr, wren, rden;
  logic [7:0] wdata;
  logic       wfull, walmost_full, rvalid, rempty, ralmost_empty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;

  logic       flush1, err_clr1, wren1, rden1;
  logic [7:0] wdata1;
  logic       wfull1, walmost_full1, rvalid1, rempty1, ralmost_empty1, overflow1, underflow1;
  logic [7:0] rdata1;
  logic [4:0] count1;

  int checks = 0;
  int failures = 0;

  sfifo_flex #(.dsize(8), .asize(4), .afull(14), .aempty(2), .oreg(0)) u0 (
    .clk(clk), .rstn(rstn), .flush(flush), .err_clr(err_clr),
    .wren(wren), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
    .rden(rden), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sfifo_flex #(.dsize(8), .asize(4), .afull(14), .aempty(2), .oreg(1)) u1 (
    .clk(clk), .rstn(rstn), .flush(flush1), .err_clr(err_clr1),
    .wren(wren1), .wdata(wdata1), .wfull(wfull1), .walmost_full(walmost_full1),
    .rden(rden1), .rdata(rdata1), .rvalid(rvalid1), .rempty(rempty1),
    .ralmost_empty(ralmost_empty1), .count(count1), .overflow(overflow1), .underflow(underflow1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model of u0: a queue of words and two sticky error bits.
  int unsigned mq[$];
  bit m_ovf, m_udf;
  bit m_full, m_empty;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_full  = (mq.size() == 16);
      m_empty = (mq.size() == 0);
      m_ovf = (wren && m_full)  || (m_ovf && !err_clr);
      m_udf = (rden && m_empty) || (m_udf && !err_clr);
      if (rden && !m_empty) void'(mq.pop_front());
      if (wren && !m_full)  mq.push_back(int'(wdata));
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("m_count", 32'(count), mq.size());
      chk("m_rempty", 32'(rempty), 32'(mq.size() == 0));
      chk("m_wfull", 32'(wfull), 32'(mq.size() == 16));
      chk("m_walmost_full", 32'(walmost_full), 32'(mq.size() >= 14));
      chk("m_ralmost_empty", 32'(ralmost_empty), 32'(mq.size() <= 2));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_udf));
      chk("m_rvalid", 32'(rvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("m_rdata", 32'(rdata), mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] d);
    wren = 1'b1; wdata = d;
    step();
    wren = 1'b0;
  endtask

  task automatic rd();
    rden = 1'b1;
    step();
    rden = 1'b0;
  endtask

  initial begin
    int wn, rn, guard;
    rstn = 1'b0; flush = 1'b0; err_clr = 1'b0; wren = 1'b0; rden = 1'b0; wdata = '0;
    flush1 = 1'b0; err_clr1 = 1'b0; wren1 = 1'b0; rden1 = 1'b0; wdata1 = '0;
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_ralmost_empty", 32'(ralmost_empty), 1);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    rstn = 1'b1;
    step();

    // 1: async reset mid-run
    for (int i = 0; i < 7; i++) wr(8'(i + 8'h10));
    chk("t1_count7", 32'(count), 7);
    rstn = 1'b0;
    #1;
    chk("t1_async_count", 32'(count), 0);
    chk("t1_async_rempty", 32'(rempty), 1);
    chk("t1_async_rvalid", 32'(rvalid), 0);
    step();
    chk("t1_held_count", 32'(count), 0);
    rstn = 1'b1;
    step();
    wr(8'h5A);
    chk("t1_rdata", 32'(rdata), 32'h5A);
    rd();
    chk("t1_count0", 32'(count), 0);

    // 2: fill and drain
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      if (i == 12) chk("t2_afull_13", 32'(walmost_full), 0);
      if (i == 13) chk("t2_afull_14", 32'(walmost_full), 1);
      if (i == 14) chk("t2_wfull_15", 32'(wfull), 0);
    end
    chk("t2_wfull", 32'(wfull), 1);
    chk("t2_count16", 32'(count), 16);
    wr(8'hAA);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_count_hold", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 32'(rdata), i);
      rd();
      if (i == 12) chk("t2_aempty_3", 32'(ralmost_empty), 0);
      if (i == 13) chk("t2_aempty_2", 32'(ralmost_empty), 1);
    end
    chk("t2_rempty", 32'(rempty), 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t2_ovf_clr", 32'(overflow), 0);

    // 3: simultaneous read and write
    for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
    wren = 1'b1; rden = 1'b1; wdata = 8'h25; step(); wren = 1'b0; rden = 1'b0;
    chk("t3_mid_count", 32'(count), 5);
    for (int i = 0; i < 11; i++) wr(8'(8'h30 + i));
    chk("t3_full", 32'(wfull), 1);
    wren = 1'b1; rden = 1'b1; wdata = 8'hEE; step(); wren = 1'b0; rden = 1'b0;
    chk("t3_full_count", 32'(count), 15);
    chk("t3_full_ovf", 32'(overflow), 1);
    for (int i = 0; i < 15; i++) rd();
    chk("t3_empty", 32'(rempty), 1);
    wren = 1'b1; rden = 1'b1; wdata = 8'h77; step(); wren = 1'b0; rden = 1'b0;
    chk("t3_empty_count", 32'(count), 1);
    chk("t3_empty_udf", 32'(underflow), 1);
    chk("t3_empty_rdata", 32'(rdata), 32'h77);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 0);
    chk("t3_clr_udf", 32'(underflow), 0);
    rd();

    // 4: wrap with random handshakes
    wn = 0; rn = 0; guard = 0;
    while (rn < 40 && guard < 2000) begin
      wren  = (wn < 40) && (mq.size() < 16) && ($urandom_range(0, 1) == 1);
      wdata = 8'(wn);
      rden  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (rden) begin
        chk("t4_order", 32'(rdata), rn);
        rn++;
      end
      if (wren) wn++;
      step();
      guard++;
    end
    wren = 1'b0; rden = 1'b0;
    chk("t4_done", rn, 40);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_udf", 32'(underflow), 0);

    // 5: flush beats concurrent write
    for (int i = 0; i < 9; i++) wr(8'(8'h50 + i));
    chk("t5_count9", 32'(count), 9);
    flush = 1'b1; wren = 1'b1; wdata = 8'h33; step(); flush = 1'b0; wren = 1'b0;
    chk("t5_count0", 32'(count), 0);
    chk("t5_rempty", 32'(rempty), 1);
    chk("t5_no_ovf", 32'(overflow), 0);
    wr(8'h44);
    chk("t5_rdata", 32'(rdata), 32'h44);
    rd();

    // 6: registered output variant
    wren1 = 1'b1; wdata1 = 8'h11; step();
    wdata1 = 8'h22; step();
    wren1 = 1'b0;
    chk("t6_rvalid_idle", 32'(rvalid1), 0);
    rden1 = 1'b1; step(); rden1 = 1'b0;
    chk("t6_rvalid_n1", 32'(rvalid1), 1);
    chk("t6_rdata_n1", 32'(rdata1), 32'h11);
    step();
    chk("t6_rvalid_n2", 32'(rvalid1), 0);
    chk("t6_rdata_hold", 32'(rdata1), 32'h11);
    chk("t6_count1", 32'(count1), 1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
